// File: rtl/kmac_msg_packer.sv
// rtl/kmac_msg_packer.sv - packs strobed message writes densely into OutW-bit words
module kmac_msg_packer #(
  parameter int InW  = 32,
  parameter int OutW = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic [InW-1:0]      data_i,
  input  logic [InW/8-1:0]    strb_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic [OutW-1:0]     data_o,
  output logic [OutW/8-1:0]   strb_o,
  input  logic                ready_i,
  input  logic                flush_i,
  output logic                flush_done_o,
  output logic                err_o
);

  localparam int InB  = InW / 8;
  localparam int OutB = OutW / 8;
  localparam int BufB = (OutW + InW) / 8;
  localparam int BufW = BufB * 8;
  localparam int PosW = $clog2(BufB + 1);
  localparam logic [PosW-1:0] OutBP = PosW'(OutB);

  typedef enum logic {
    StRun,
    StFlush
  } st_e;

  st_e             st_q, st_d;
  logic [BufW-1:0] pbuf_q, pbuf_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  // Output decode: valid when a full word is buffered, or any bytes remain while flushing
  logic            full;
  logic            valid;
  logic            ready;
  logic [PosW-1:0] emit_n;
  logic [OutB-1:0] strb_emit;

  always_comb begin
    full   = (pos_q >= OutBP);
    valid  = full || ((st_q == StFlush) && (pos_q != '0));
    ready  = (st_q == StRun) && (pos_q <= OutBP);
    emit_n = full ? OutBP : pos_q;
    strb_emit = '0;
    for (int i = 0; i < OutB; i++) begin
      strb_emit[i] = valid && (PosW'(i) < emit_n);
    end
  end

  assign ready_o      = ready;
  assign valid_o      = valid;
  // Bytes at or above pos are always zero, so the low word is already zero-padded
  assign data_o       = valid ? pbuf_q[OutW-1:0] : '0;
  assign strb_o       = strb_emit;
  assign flush_done_o = done_q;
  assign err_o        = err_q;

  // Next state: shift out the emitted bytes first, then append the accepted beat
  logic            fire;
  logic            accept;
  logic            legal;
  logic [PosW-1:0] shift_n;
  logic [PosW-1:0] pos_mid;
  logic [PosW-1:0] n_in;
  logic [BufW-1:0] pbuf_shift;
  logic [BufW-1:0] data_m;

  always_comb begin
    fire       = valid && ready_i;
    accept     = valid_i && ready;
    shift_n    = fire ? emit_n : '0;
    pbuf_shift = pbuf_q >> {shift_n, 3'b000};
    pos_mid    = pos_q - shift_n;
    // Contiguous-from-bit-0 strobes are exactly those where strb & (strb+1) is zero
    legal      = ((strb_i & (strb_i + InB'(1))) == '0);
    n_in       = '0;
    data_m     = '0;
    for (int i = 0; i < InB; i++) begin
      n_in = n_in + PosW'(strb_i[i]);
      data_m[8*i +: 8] = strb_i[i] ? data_i[8*i +: 8] : 8'h00;
    end

    pbuf_d = pbuf_shift;
    pos_d  = pos_mid;
    err_d  = 1'b0;
    if (accept) begin
      if (legal) begin
        pbuf_d = pbuf_shift | (data_m << {pos_mid, 3'b000});
        pos_d  = pos_mid + n_in;
      end else begin
        err_d = 1'b1;
      end
    end

    st_d   = st_q;
    done_d = 1'b0;
    case (st_q)
      StRun: begin
        if (flush_i) begin
          st_d = StFlush;
        end
      end
      StFlush: begin
        if (pos_d == '0) begin
          st_d   = StRun;
          done_d = 1'b1;
        end
      end
      default: st_d = StRun;
    endcase
  end

  // State and registered pulse outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= StRun;
      pbuf_q <= '0;
      pos_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      pbuf_q <= pbuf_d;
      pos_q  <= pos_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_kmac_msg_packer.sv
// tb/tb_kmac_msg_packer.sv - randomized self-checking bench with byte-queue reference model
module tb_kmac_msg_packer;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] data_i;
  logic [3:0]  strb_i;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] data_o;
  logic [7:0]  strb_o;
  logic        ready_i;
  logic        flush_i;
  logic        flush_done_o;
  logic        err_o;

  kmac_msg_packer #(.InW(32), .OutW(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .strb_i       (strb_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .strb_o       (strb_o),
    .ready_i      (ready_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes held by the packer, flush mode, pending pulses
  logic [7:0] q[$];
  bit         flushing;
  bit         done_e;
  bit         err_e;
  int         done_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    flushing = 1'b0;
    done_e   = 1'b0;
    err_e    = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_strb", strb_o, 0);
    check("rst_done", flush_done_o, 0);
    check("rst_err", err_o, 0);
  endtask

  function automatic int popcnt(input logic [3:0] s);
    int c = 0;
    for (int i = 0; i < 4; i++) c += s[i];
    return c;
  endfunction

  // One cycle: compare at negedge, drive inputs, advance the model, cross posedge
  task automatic step(input bit vi, input logic [31:0] di, input logic [3:0] si,
                      input bit fi, input bit ri);
    int          sz;
    int          emit;
    bit          rdy_e;
    bit          vld_e;
    bit          acc;
    bit          legal;
    logic [63:0] data_e;
    logic [7:0]  strb_e;
    sz     = q.size();
    rdy_e  = !flushing && (sz <= 8);
    vld_e  = (sz >= 8) || (flushing && sz > 0);
    emit   = vld_e ? ((sz >= 8) ? 8 : sz) : 0;
    data_e = '0;
    strb_e = '0;
    for (int i = 0; i < emit; i++) begin
      data_e[8*i +: 8] = q[i];
      strb_e[i] = 1'b1;
    end
    check("ready", ready_o, rdy_e);
    check("valid", valid_o, vld_e);
    check("flush_done", flush_done_o, done_e);
    check("err", err_o, err_e);
    if (vld_e) begin
      check("data", data_o, data_e);
      check("strb", strb_o, strb_e);
    end
    if (flush_done_o) done_cnt++;

    valid_i = vi;
    data_i  = di;
    strb_i  = si;
    flush_i = fi;
    ready_i = ri;

    if (vld_e && ri) begin
      for (int i = 0; i < emit; i++) void'(q.pop_front());
    end
    acc   = vi && rdy_e;
    legal = si inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    err_e = acc && !legal;
    if (acc && legal) begin
      for (int i = 0; i < popcnt(si); i++) q.push_back(di[8*i +: 8]);
    end
    done_e = 1'b0;
    if (!flushing) begin
      if (fi) flushing = 1'b1;
    end else if (q.size() == 0) begin
      flushing = 1'b0;
      done_e   = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles, input bit ri);
    for (int i = 0; i < cycles; i++) step(0, 32'h0, 4'h0, 0, ri);
  endtask

  logic [3:0] legal_strb [5];
  int         dc;
  logic [63:0] held;

  initial begin
    legal_strb[0] = 4'h0; legal_strb[1] = 4'h1; legal_strb[2] = 4'h3;
    legal_strb[3] = 4'h7; legal_strb[4] = 4'hF;
    rst_n = 1'b0; valid_i = 0; data_i = 0; strb_i = 0; flush_i = 0; ready_i = 1;
    model_reset();
    done_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Basic pack
    step(1, 32'h03020100, 4'hF, 0, 1);
    step(1, 32'h07060504, 4'hF, 0, 1);
    check("basic_data", data_o, 64'h0706050403020100);
    check("basic_strb", strb_o, 8'hFF);
    idle(2, 1);

    // Odd strobes then flush: partial word holds byte 8
    step(1, 32'h00020100, 4'h7, 0, 1);
    step(1, 32'h00050403, 4'h7, 0, 1);
    step(1, 32'h00080706, 4'h7, 0, 1);
    check("odd_strb_full", strb_o, 8'hFF);
    step(0, 0, 4'h0, 1, 1);
    check("odd_strb_part", strb_o, 8'h01);
    check("odd_data_part", data_o, 64'h08);
    dc = done_cnt;
    idle(4, 1);
    check("odd_done_once", done_cnt - dc, 1);

    // Backpressure: fill to 12 bytes, verify held output, then drain
    for (int i = 0; i < 4; i++) step(1, $urandom, 4'hF, 0, 0);
    check("bp_ready_low", ready_o, 0);
    held = data_o;
    step(1, $urandom, 4'hF, 0, 0);
    check("bp_hold", data_o, held);
    idle(4, 1);

    // Empty flush
    dc = done_cnt;
    step(0, 0, 4'h0, 1, 1);
    check("eflush_ready", ready_o, 0);
    idle(3, 1);
    check("eflush_done_once", done_cnt - dc, 1);

    // Illegal strobe, then a legal beat lands at the old offset
    step(1, 32'hAABBCCDD, 4'h3, 0, 1);
    step(1, 32'h11223344, 4'b0101, 0, 1);
    check("ill_err", err_o, 1);
    step(1, 32'h55667788, 4'hF, 0, 1);
    step(1, 32'h99000000, 4'h7, 0, 1);
    check("ill_offset", data_o, 64'h0000_5566_7788_CCDD);
    idle(3, 1);
    step(0, 0, 4'h0, 1, 1);
    idle(4, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 19) == 0) ? 4'(($urandom_range(0, 3) == 0) ? 4'b0101 : 4'b1010)
                                       : legal_strb[$urandom_range(0, 4)];
      step($urandom_range(0, 3) != 0, $urandom, s,
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    step(0, 0, 4'h0, 1, 1);
    idle(6, 1);

    // Reset in the middle of a flush with pos = 5
    step(1, 32'h04030201, 4'hF, 0, 1);
    step(1, 32'h00000005, 4'h1, 0, 0);
    step(0, 0, 4'h0, 1, 0);
    check("rf_valid", valid_o, 1);
    check("rf_strb", strb_o, 8'h1F);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    idle(5, 1);
    check("rf_no_done", done_cnt - dc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
